fetch_ir: RTL and testbench
===========================

Name: fetch_ir

Overview:
Instruction fetch and instruction-register stage of the multicycle MIPS datapath, directly upstream of signextend.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into a single-entry instruction register (IR).
- Presents the decoded fields, including imm16_ir, which feeds signextend.
- Supports PC redirect (branch/jump) with squash of any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous reset, active-high
fetch_en  input  1  permission to start a new fetch
ir_consume  input  1  downstream has taken the current IR contents
pc_we  input  1  redirect: load pc_next into PC, flush IR and in-flight fetch
pc_next  input  32  redirect target; bits [1:0] forced to 0 on load
mem_req  output  1  read request to instruction memory (registered)
mem_addr  output  32  word address of request; equals PC, stable while mem_req=1
mem_ack  input  1  memory returns data this cycle (only meaningful while mem_req=1)
mem_rdata  input  32  instruction word, valid with mem_ack
ir_valid  output  1  IR holds a valid, unconsumed instruction
instr  output  32  IR contents
instr_pc  output  32  address the IR word was fetched from
pc_plus4  output  32  instr_pc + 4 (mod 2^32)
opcode  output  6  instr[31:26]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
shamt  output  5  instr[10:6]
funct  output  6  instr[5:0]
imm16_ir  output  16  instr[15:0], to signextend
target26  output  26  instr[25:0]

Behaviour:
Reset, synchronous and dominant over all other inputs:
- PC=RESET_PC; state=IDLE; mem_req=0; ir_valid=0; instr=0; instr_pc=0; squash=0.
- All field outputs are therefore 0.
- Reset while in WAIT abandons the request: mem_req drops the next cycle, and any later ack is ignored because mem_req=0.

State machine, states IDLE and WAIT:
- IDLE, issue condition = fetch_en && !pc_we && (!ir_valid || ir_consume). When true: next state WAIT, mem_req<=1, mem_addr=PC.
- WAIT: mem_req=1 and mem_addr held until mem_ack.
- WAIT with mem_ack and !squash and !pc_we: instr<=mem_rdata, instr_pc<=PC, PC<=PC+4, ir_valid<=1, mem_req<=0, next state IDLE.
- WAIT with mem_ack and (squash or pc_we): data discarded, ir_valid unchanged from flush, squash<=0, mem_req<=0, next state IDLE.
- WAIT with !mem_ack and pc_we: squash<=1; stay in WAIT. The address is not changed mid-request.

Redirect, pc_we=1, in any state:
- PC<={pc_next[31:2],2'b00}.
- ir_valid<=0.
- pc_we has priority over ir_consume and over mem_ack fill.

Consume:
- ir_consume with ir_valid=1 clears ir_valid next cycle.
- ir_consume with ir_valid=0 is ignored.
- A fill cannot coincide with a consume, because issue requires the IR to be empty or emptying.

Latency:
- Issue at cycle t; mem_req=1 at t+1.
- Ack at t+1 gives ir_valid=1 at t+2. Each extra wait cycle adds one.
- Throughput with a zero-wait memory is one instruction per 2 cycles.

Arithmetic:
- PC+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- Field outputs are combinational slices of the IR register. No sign extension is done here.

Decomposition:
- Shared package mips_defs:
  - state encoding (IDLE/WAIT)
  - field bit-position constants (OPC_HI=31, RS_LO=21, ...)
  - default RESET_PC
- One natural sub-module: ir_fields. Purely combinational; splits the 32-bit IR into opcode/rs/rt/rd/shamt/funct/imm16_ir/target26. It is reused by the decoder bench.

Test Plan:
1. Reset then fetch_en=1, mem_ack on first req cycle, mem_rdata=32'h2008_A000 -> mem_addr=0, ir_valid at cycle 2, imm16_ir=16'hA000, opcode=6'h08, rt=8, instr_pc=0, PC=4.
2. Back-to-back, ir_consume each time ir_valid=1, 3-cycle memory latency -> mem_addr sequence 0,4,8; mem_addr stable across the wait cycles; no second req while IR full without consume.
3. pc_we=1, pc_next=32'h0000_0103 during WAIT with ack 2 cycles later -> that ack's data discarded, ir_valid stays 0, next request mem_addr=32'h0000_0100.
4. pc_we and mem_ack in same cycle -> data discarded, PC=pc_next, ir_valid=0, next state IDLE.
5. RESET_PC=32'hFFFF_FFFC, one fetch -> instr_pc=32'hFFFF_FFFC, pc_plus4=0, next mem_addr=0.
6. reset asserted mid-WAIT, then mem_ack -> mem_req=0 after reset, ir_valid=0, all outputs 0, next fetch at RESET_PC.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the multicycle MIPS front end: fetch FSM encoding,
// instruction field bit positions and the default reset PC.
package mips_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ir_fields.sv
// Combinational split of a 32-bit MIPS instruction word into its R/I/J fields.
module ir_fields
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16_ir,
  output logic [25:0] target26
);

  assign opcode   = instr[OPC_HI:OPC_LO];
  assign rs       = instr[RS_HI:RS_LO];
  assign rt       = instr[RT_HI:RT_LO];
  assign rd       = instr[RD_HI:RD_LO];
  assign shamt    = instr[SH_HI:SH_LO];
  assign funct    = instr[FN_HI:FN_LO];
  assign imm16_ir = instr[IMM_HI:IMM_LO];
  assign target26 = instr[TGT_HI:TGT_LO];

endmodule

// File: rtl/fetch_ir.sv
// Instruction fetch + single-entry instruction register with req/ack memory
// port and branch/jump redirect that squashes an in-flight fetch.
module fetch_ir
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        ir_consume,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ir_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16_ir,
  output logic [25:0] target26
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         mem_req_q, mem_req_d;
  logic         ir_valid_q, ir_valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         squash_q, squash_d;
  logic         issue;

  // The request address lives in its own register so a redirect can move the
  // PC immediately without disturbing a request that is still outstanding.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    mem_req_d  = mem_req_q;
    ir_valid_d = ir_valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    squash_d   = squash_q;

    issue = (state_q == ST_IDLE) && fetch_en && !pc_we && (!ir_valid_q || ir_consume);

    if (ir_consume && ir_valid_q) begin
      ir_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b1;
          addr_d    = pc_q;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          squash_d  = 1'b0;
          if (!squash_q && !pc_we) begin
            instr_d    = mem_rdata;
            instr_pc_d = addr_q;
            pc_d       = pc_q + 32'd4;
            ir_valid_d = 1'b1;
          end
        end else if (pc_we) begin
          squash_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Redirect wins over consume and over a same-cycle fill.
    if (pc_we) begin
      pc_d       = {pc_next[31:2], 2'b00};
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      mem_req_q  <= mem_req_d;
      ir_valid_q <= ir_valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      squash_q   <= squash_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = addr_q;
  assign ir_valid = ir_valid_q;
  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;
  assign pc_plus4 = instr_pc_q + 32'd4;

  ir_fields u_fields (
    .instr    (instr_q),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm16_ir (imm16_ir),
    .target26 (target26)
  );

endmodule

// File: tb/tb_fetch_ir.sv
// Directed bench for fetch_ir: reset, single fetch, back-to-back fetches,
// redirect squash, PC wrap and reset during an outstanding request.
module tb_fetch_ir;

  logic        clk = 1'b0;
  logic        reset, fetch_en, ir_consume, pc_we, mem_ack;
  logic [31:0] pc_next, mem_rdata;

  logic        mem_req, ir_valid;
  logic [31:0] mem_addr, instr, instr_pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16_ir;
  logic [25:0] target26;

  logic        w_mem_req, w_ir_valid;
  logic [31:0] w_mem_addr, w_instr, w_instr_pc, w_pc_plus4;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm16_ir;
  logic [25:0] w_target26;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ir dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .ir_consume(ir_consume),
    .pc_we(pc_we), .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_valid(ir_valid), .instr(instr),
    .instr_pc(instr_pc), .pc_plus4(pc_plus4), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm16_ir(imm16_ir), .target26(target26)
  );

  fetch_ir #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .ir_consume(ir_consume),
    .pc_we(pc_we), .pc_next(pc_next), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_valid(w_ir_valid), .instr(w_instr),
    .instr_pc(w_instr_pc), .pc_plus4(w_pc_plus4), .opcode(w_opcode), .rs(w_rs),
    .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .funct(w_funct), .imm16_ir(w_imm16_ir),
    .target26(w_target26)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; fetch_en = 1'b0; ir_consume = 1'b0; pc_we = 1'b0;
    pc_next = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rst_ir_valid got=%0h exp=0", ir_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%08h exp=00000000", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%08h exp=00000000", instr_pc); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_pc_plus4 got=%08h exp=00000004", pc_plus4); end
    total++; if (target26 !== 26'h0) begin bad++; $display("FAIL rst_target26 got=%07h exp=0", target26); end
    // idle with nothing requested: no spontaneous request
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req got=%0h exp=0", mem_req); end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    fetch_en = 1'b1;
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL t1_req got=%0h exp=1", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL t1_addr got=%08h exp=00000000", mem_addr); end
    fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h2008_A000;
    tick();
    mem_ack = 1'b0;
    total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%0h exp=1", ir_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL t1_req_drop got=%0h exp=0", mem_req); end
    total++; if (instr !== 32'h2008_A000) begin bad++; $display("FAIL t1_instr got=%08h exp=2008a000", instr); end
    total++; if (imm16_ir !== 16'hA000) begin bad++; $display("FAIL t1_imm got=%04h exp=a000", imm16_ir); end
    total++; if (opcode !== 6'h08) begin bad++; $display("FAIL t1_opcode got=%02h exp=08", opcode); end
    total++; if (rt !== 5'd8) begin bad++; $display("FAIL t1_rt got=%0d exp=8", rt); end
    total++; if (rs !== 5'd0) begin bad++; $display("FAIL t1_rs got=%0d exp=0", rs); end
    total++; if (rd !== 5'd20) begin bad++; $display("FAIL t1_rd got=%0d exp=20", rd); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL t1_instr_pc got=%08h exp=00000000", instr_pc); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL t1_pc_plus4 got=%08h exp=00000004", pc_plus4); end
    // consume and fetch again: request goes to the incremented PC
    ir_consume = 1'b1; fetch_en = 1'b1;
    tick();
    ir_consume = 1'b0; fetch_en = 1'b0;
    total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL t1_next_addr got=%08h exp=00000004", mem_addr); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL t1_consumed got=%0h exp=0", ir_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    apply_reset();
    fetch_en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_addr = 32'(4 * k);
      for (int w = 0; w < 3; w++) begin
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL b2b_req k=%0d w=%0d got=%0h exp=1", k, w, mem_req); end
        total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL b2b_addr k=%0d w=%0d got=%08h exp=%08h", k, w, mem_addr, exp_addr); end
        if (w == 2) begin mem_ack = 1'b1; mem_rdata = 32'h1000_0000 + 32'(k); end
        tick();
      end
      mem_ack = 1'b0;
      total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d got=%0h exp=1", k, ir_valid); end
      total++; if (instr !== 32'h1000_0000 + 32'(k)) begin bad++; $display("FAIL b2b_instr k=%0d got=%08h exp=%08h", k, instr, 32'h1000_0000 + 32'(k)); end
      total++; if (instr_pc !== exp_addr) begin bad++; $display("FAIL b2b_instr_pc k=%0d got=%08h exp=%08h", k, instr_pc, exp_addr); end
      tick();
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_full_noreq k=%0d got=%0h exp=0", k, mem_req); end
      total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL b2b_held k=%0d got=%0h exp=1", k, ir_valid); end
      ir_consume = 1'b1;
      tick();
      ir_consume = 1'b0;
      total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL b2b_consume k=%0d got=%0h exp=0", k, ir_valid); end
    end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; pc_we = 1'b1; pc_next = 32'h0000_0103;
    tick();
    pc_we = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL t3_req_held got=%0h exp=1", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL t3_addr_held got=%08h exp=00000000", mem_addr); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL t3_discard got=%0h exp=0", ir_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL t3_req_drop got=%0h exp=0", mem_req); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL t3_instr got=%08h exp=00000000", instr); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    total++; if (mem_addr !== 32'h0000_0100) begin bad++; $display("FAIL t3_redir_addr got=%08h exp=00000100", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0123_4567;
    tick();
    mem_ack = 1'b0;
    total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL t3_refill got=%0h exp=1", ir_valid); end
    total++; if (instr_pc !== 32'h0000_0100) begin bad++; $display("FAIL t3_refill_pc got=%08h exp=00000100", instr_pc); end
  endtask

  task automatic test_redirect_ack();
    apply_reset();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; pc_we = 1'b1; pc_next = 32'h0000_0200; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    pc_we = 1'b0; mem_ack = 1'b0;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL t4_discard got=%0h exp=0", ir_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL t4_idle got=%0h exp=0", mem_req); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL t4_reissue got=%0h exp=1", mem_req); end
    total++; if (mem_addr !== 32'h0000_0200) begin bad++; $display("FAIL t4_addr got=%08h exp=00000200", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
    tick();
    mem_ack = 1'b0;
    total++; if (instr !== 32'h0000_1111) begin bad++; $display("FAIL t4_fill got=%08h exp=00001111", instr); end
    // redirect flushes a full IR and blocks issue in the same cycle
    fetch_en = 1'b1; ir_consume = 1'b1; pc_we = 1'b1; pc_next = 32'h0000_0300;
    tick();
    fetch_en = 1'b0; ir_consume = 1'b0; pc_we = 1'b0;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL t4_flush got=%0h exp=0", ir_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL t4_block got=%0h exp=0", mem_req); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    total++; if (mem_addr !== 32'h0000_0300) begin bad++; $display("FAIL t4_addr2 got=%08h exp=00000300", mem_addr); end
  endtask

  task automatic test_wrap();
    apply_reset();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    total++; if (w_mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL t5_addr got=%08h exp=fffffffc", w_mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h3C01_1234;
    tick();
    mem_ack = 1'b0;
    total++; if (w_instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL t5_instr_pc got=%08h exp=fffffffc", w_instr_pc); end
    total++; if (w_pc_plus4 !== 32'h0) begin bad++; $display("FAIL t5_pc_plus4 got=%08h exp=00000000", w_pc_plus4); end
    total++; if (w_opcode !== 6'h0F) begin bad++; $display("FAIL t5_opcode got=%02h exp=0f", w_opcode); end
    ir_consume = 1'b1; fetch_en = 1'b1;
    tick();
    ir_consume = 1'b0; fetch_en = 1'b0;
    total++; if (w_mem_req !== 1'b1) begin bad++; $display("FAIL t5_req got=%0h exp=1", w_mem_req); end
    total++; if (w_mem_addr !== 32'h0) begin bad++; $display("FAIL t5_next_addr got=%08h exp=00000000", w_mem_addr); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0; ir_consume = 1'b1; fetch_en = 1'b1;
    tick();
    ir_consume = 1'b0; fetch_en = 1'b0;
    total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL t6_pre_addr got=%08h exp=00000004", mem_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL t6_req got=%0h exp=0", mem_req); end
    tick();
    mem_ack = 1'b0;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL t6_valid got=%0h exp=0", ir_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL t6_instr got=%08h exp=00000000", instr); end
    total++; if (imm16_ir !== 16'h0) begin bad++; $display("FAIL t6_imm got=%04h exp=0000", imm16_ir); end
    total++; if (funct !== 6'h0) begin bad++; $display("FAIL t6_funct got=%02h exp=00", funct); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL t6_instr_pc got=%08h exp=00000000", instr_pc); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL t6_refetch got=%0h exp=1", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL t6_refetch_addr got=%08h exp=00000000", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
